cache_mem_ctrl: RTL

Cache-side initiator for the block-memory port. Takes one cache-line request at a time from the cache FSM: a refill, a dirty-line writeback, or a writeback followed by a refill. It drives the enable-held, ready-pulse memory protocol (ram_en, ram_write, ram_addr, data_to_ram; ram_rdy, block_out) and returns the refilled 256-bit line, or an error on timeout, with a one-cycle response strobe.

---
 rtl/cache_mem_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cache_mem_ctrl.sv
// Cache line initiator for the block-memory port: optional writeback, then refill.
// Accept-to-ram_en 1 cycle, response 1 cycle after ram_rdy; req_ready low until the response retires.
module cache_mem_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_rd_i,
    input  logic         req_wr_i,
    input  logic [10:0]  req_rd_addr_i,
    input  logic [10:0]  req_wr_addr_i,
    input  logic [255:0] req_wr_data_i,
    output logic         resp_valid_o,
    output logic         resp_err_o,
    output logic [255:0] resp_data_o,
    output logic         ram_en_o,
    output logic         ram_write_o,
    output logic [10:0]  ram_addr_o,
    output logic [255:0] data_to_ram_o,
    input  logic         ram_rdy_i,
    input  logic [255:0] block_out_i
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_GAP,
        S_RD,
        S_RESP
    } state_t;

    state_t         state_q;
    logic           req_ready_q;
    logic           resp_valid_q;
    logic           err_q;
    logic [255:0]   resp_data_q;
    logic           ram_en_q;
    logic           ram_write_q;
    logic [10:0]    ram_addr_q;
    logic [255:0]   data_to_ram_q;
    logic           rd_q;
    logic [10:0]    rd_addr_q;
    logic [WDW-1:0] wd_q;
    logic [WDW-1:0] wd_d;
    logic           rdy_ok;

    // A zero watchdog marks the first enabled cycle, where a stale ram_rdy must be ignored.
    always_comb begin
        wd_d   = wd_q + WDW'(1);
        rdy_ok = ram_rdy_i && (wd_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            err_q         <= 1'b0;
            resp_data_q   <= '0;
            ram_en_q      <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_addr_q    <= '0;
            data_to_ram_q <= '0;
            rd_q          <= 1'b0;
            rd_addr_q     <= '0;
            wd_q          <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        err_q     <= 1'b0;
                        rd_q      <= req_rd_i;
                        rd_addr_q <= req_rd_addr_i;
                        wd_q      <= '0;
                        if (req_wr_i) begin
                            state_q       <= S_WB;
                            req_ready_q   <= 1'b0;
                            ram_en_q      <= 1'b1;
                            ram_write_q   <= 1'b1;
                            ram_addr_q    <= req_wr_addr_i;
                            data_to_ram_q <= req_wr_data_i;
                        end else if (req_rd_i) begin
                            state_q     <= S_RD;
                            req_ready_q <= 1'b0;
                            ram_en_q    <= 1'b1;
                            ram_write_q <= 1'b0;
                            ram_addr_q  <= req_rd_addr_i;
                        end
                    end
                end
                S_WB, S_RD: begin
                    wd_q <= wd_d;
                    // ram_rdy takes priority over an expiring watchdog in the same cycle.
                    if (rdy_ok) begin
                        ram_en_q <= 1'b0;
                        if (state_q == S_RD) begin
                            resp_data_q <= block_out_i;
                        end
                        if (state_q == S_WB && rd_q) begin
                            state_q <= S_GAP;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end else if (wd_d == WD_LIMIT) begin
                        ram_en_q     <= 1'b0;
                        err_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_GAP: begin
                    state_q     <= S_RD;
                    ram_en_q    <= 1'b1;
                    ram_write_q <= 1'b0;
                    ram_addr_q  <= rd_addr_q;
                    wd_q        <= '0;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    ram_en_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_err_o    = err_q;
    assign resp_data_o   = resp_data_q;
    assign ram_en_o      = ram_en_q;
    assign ram_write_o   = ram_write_q;
    assign ram_addr_o    = ram_addr_q;
    assign data_to_ram_o = data_to_ram_q;

endmodule
